// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants: FSM encoding, oversampling ticks, parity.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [3:0] TICK_MID_0 = 4'd7;
  localparam logic [3:0] TICK_MID_1 = 4'd8;
  localparam logic [3:0] TICK_MID_2 = 4'd9;
  localparam logic [3:0] TICK_LAST  = 4'd15;

  function automatic logic parity_of(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Clock divider producing a one-clk tick every DIV clks, with sync clear.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] r_cnt;
  logic         w_wrap;

  assign w_wrap = (r_cnt == W'(DIV - 1));
  assign tick   = w_wrap && !clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else if (clear || w_wrap)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os
// Description : 8-bit 16x-oversampled UART receiver with parity/stop/overrun status.
//               Optional UART_RX_BREAK_DETECT_EN adds break_det and suppresses break frames.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       parity_bit,
  output logic       parity_error,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic       break_det
`endif
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

  logic       r_sync1, r_sync2, r_line_q;
  logic [2:0] r_state, w_state_next;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_idx;
  logic       r_s7, r_s8, r_par_rx;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_valid, r_pbit, r_perr, r_ferr, r_overrun;
  logic       w_line, w_fall, w_tick, w_clear, w_busy;
  logic       w_maj, w_mid, w_last, w_complete, w_deliver, w_accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_line_q <= 1'b1;
    end else begin
      r_sync1  <= serial_in;
      r_sync2  <= r_sync1;
      r_line_q <= r_sync2;
    end
  end

  assign w_line = r_sync2;
  assign w_fall = r_line_q && !w_line;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Third vote is taken live on the tick-9 cycle, so the decision lands there.
  assign w_maj      = (r_s7 & r_s8) | (r_s7 & w_line) | (r_s8 & w_line);
  assign w_mid      = w_tick && (r_tick_cnt == TICK_MID_2);
  assign w_last     = w_tick && (r_tick_cnt == TICK_LAST);
  assign w_complete = (r_state == STOP) && w_mid;
  assign w_accept   = r_valid && data_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_state_next = START;
      START: begin
        if (w_mid && w_maj)
          w_state_next = IDLE;
        else if (w_last)
          w_state_next = DATA;
      end
      DATA:    if (w_last && r_bit_idx == 3'd7) w_state_next = PARITY;
      PARITY:  if (w_last) w_state_next = STOP;
      STOP:    if (w_mid) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy  = (r_state != IDLE);
    w_clear = (r_state == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_s7       <= 1'b1;
      r_s8       <= 1'b1;
      r_shift    <= '0;
      r_par_rx   <= 1'b0;
    end else if (r_state == IDLE) begin
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
      if (r_tick_cnt == TICK_MID_0) r_s7 <= w_line;
      if (r_tick_cnt == TICK_MID_1) r_s8 <= w_line;
      if (w_mid && r_state == DATA)   r_shift  <= {w_maj, r_shift[7:1]};
      if (w_mid && r_state == PARITY) r_par_rx <= w_maj;
      if (w_last && r_state == DATA)  r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic w_is_break, r_break_det;
  assign w_is_break = (r_shift == 8'h00) && !r_par_rx && !w_maj;
  assign w_deliver  = w_complete && !w_is_break;
  assign break_det  = r_break_det;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_break_det <= 1'b0;
    else if (w_complete && w_is_break)
      r_break_det <= 1'b1;
    else if (w_line)
      r_break_det <= 1'b0;
  end
`else
  assign w_deliver = w_complete;
`endif

  // Completion is evaluated after accept so a same-cycle accept+completion keeps valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_pbit    <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
      if (w_deliver) begin
        if (!r_valid || data_ready) begin
          r_data  <= r_shift;
          r_pbit  <= r_par_rx;
          r_perr  <= r_par_rx != parity_of(r_shift, PARITY_ODD != 0);
          r_ferr  <= !w_maj;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign data_out      = r_data;
  assign data_valid    = r_valid;
  assign parity_bit    = r_pbit;
  assign parity_error  = r_perr;
  assign framing_error = r_ferr;
  assign overrun       = r_overrun;
  assign busy          = w_busy;

endmodule
`default_nettype wire
